// File: rtl/burst_checker.sv
// Receive-side checker for the "N consecutive ones" burst line: measures each high run,
// classifies it against BURST_LEN and hands one result per burst over valid/ready.

module burst_checker_chk #(
  parameter int BURST_LEN = 16,
  parameter int LEN_W     = 8
) (
  input logic             clk,
  input logic             rst_n,
  input logic             i_res_valid,
  input logic             i_res_ready,
  input logic             i_res_ok,
  input logic [LEN_W-1:0] i_res_len,
  input logic             i_busy,
  input logic             i_in_idle,
  input logic             i_in_run,
  input logic [LEN_W-1:0] i_len
);

  // A result that is not taken must be presented unchanged on the next cycle.
  a_hold_until_taken: assert property (@(posedge clk) disable iff (!rst_n)
    (i_res_valid && !i_res_ready) |=> (i_res_valid && $stable(i_res_len) && $stable(i_res_ok)));

  a_busy_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
    i_busy == !i_in_idle);

  a_run_len_range: assert property (@(posedge clk) disable iff (!rst_n)
    i_in_run |-> ((i_len >= LEN_W'(1)) && (i_len <= LEN_W'(BURST_LEN))));

  a_idle_len_zero: assert property (@(posedge clk) disable iff (!rst_n)
    i_in_idle |-> (i_len == {LEN_W{1'b0}}));

endmodule

module burst_checker #(
  parameter int BURST_LEN = 16,
  parameter int LEN_W     = 8,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_clear,
  input  logic              i_din,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic              o_res_ok,
  output logic [LEN_W-1:0]  o_res_len,
  output logic [STAT_W-1:0] o_ok_cnt,
  output logic [STAT_W-1:0] o_err_cnt,
  output logic              o_ovf,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LONG = 2'b10
  } state_t;

  localparam logic [LEN_W-1:0]  LEN_ZERO   = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_MAX    = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0]  LEN_TARGET = LEN_W'(BURST_LEN);
  localparam logic [STAT_W-1:0] STAT_ZERO  = {STAT_W{1'b0}};
  localparam logic [STAT_W-1:0] STAT_ONE   = {{(STAT_W-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0] STAT_MAX   = {STAT_W{1'b1}};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   w_len_nxt;
  logic [LEN_W-1:0]   w_len_inc;
  logic               w_eob;
  logic               w_eob_ok;
  logic               w_accept;
  logic               w_drop;

  logic               r_res_valid;
  logic               r_res_ok;
  logic [LEN_W-1:0]   r_res_len;
  logic [STAT_W-1:0]  r_ok_cnt;
  logic [STAT_W-1:0]  r_err_cnt;
  logic               r_ovf;
  logic               r_busy;

  assign w_len_inc = (r_len == LEN_MAX) ? LEN_MAX : (r_len + LEN_ONE);

  // A result can be taken when the slot is empty or is being emptied on this same edge.
  assign w_accept = w_eob && (!r_res_valid || i_res_ready);
  assign w_drop   = w_eob && r_res_valid && !i_res_ready;

  // Next-state and run-length logic; the end-of-burst sample always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_eob       = 1'b0;
    w_eob_ok    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en && i_din) begin
          w_state_nxt = ST_RUN;
          w_len_nxt   = LEN_ONE;
        end else begin
          w_state_nxt = ST_IDLE;
          w_len_nxt   = LEN_ZERO;
        end
      end
      ST_RUN: begin
        if (!i_en) begin
          w_state_nxt = ST_IDLE;
          w_len_nxt   = LEN_ZERO;
        end else if (i_din) begin
          if (r_len < LEN_TARGET) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_LONG;
          end
          w_len_nxt = w_len_inc;
        end else begin
          w_eob       = 1'b1;
          w_eob_ok    = (r_len == LEN_TARGET);
          w_state_nxt = ST_IDLE;
          w_len_nxt   = LEN_ZERO;
        end
      end
      ST_LONG: begin
        if (!i_en) begin
          w_state_nxt = ST_IDLE;
          w_len_nxt   = LEN_ZERO;
        end else if (i_din) begin
          w_state_nxt = ST_LONG;
          w_len_nxt   = w_len_inc;
        end else begin
          w_eob       = 1'b1;
          w_eob_ok    = 1'b0;
          w_state_nxt = ST_IDLE;
          w_len_nxt   = LEN_ZERO;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_len_nxt   = LEN_ZERO;
      end
    endcase
  end

  // State, run length and busy flag (busy derived from next state so it mirrors the state register).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_len   <= LEN_ZERO;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Result slot with valid/ready handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_ok    <= 1'b0;
      r_res_len   <= LEN_ZERO;
    end else if (w_accept) begin
      r_res_valid <= 1'b1;
      r_res_ok    <= w_eob_ok;
      r_res_len   <= r_len;
    end else if (r_res_valid && i_res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  // Sticky overflow flag; clear dominates a same-cycle drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (i_clear) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  // Saturating statistics, counted on every end of burst whether or not the result was kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ok_cnt  <= STAT_ZERO;
      r_err_cnt <= STAT_ZERO;
    end else if (i_clear) begin
      r_ok_cnt  <= STAT_ZERO;
      r_err_cnt <= STAT_ZERO;
    end else if (w_eob) begin
      if (w_eob_ok) begin
        r_ok_cnt <= (r_ok_cnt == STAT_MAX) ? STAT_MAX : (r_ok_cnt + STAT_ONE);
      end else begin
        r_err_cnt <= (r_err_cnt == STAT_MAX) ? STAT_MAX : (r_err_cnt + STAT_ONE);
      end
    end
  end

  assign o_res_valid = r_res_valid;
  assign o_res_ok    = r_res_ok;
  assign o_res_len   = r_res_len;
  assign o_ok_cnt    = r_ok_cnt;
  assign o_err_cnt   = r_err_cnt;
  assign o_ovf       = r_ovf;
  assign o_busy      = r_busy;

  burst_checker_chk #(
    .BURST_LEN (BURST_LEN),
    .LEN_W     (LEN_W)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_res_valid (r_res_valid),
    .i_res_ready (i_res_ready),
    .i_res_ok    (r_res_ok),
    .i_res_len   (r_res_len),
    .i_busy      (r_busy),
    .i_in_idle   (r_state == ST_IDLE),
    .i_in_run    (r_state == ST_RUN),
    .i_len       (r_len)
  );

endmodule

// File: tb/tb_burst_checker.sv
// Bench for burst_checker: run-length reference model compared every cycle, plus
// hand-computed literal expectations at the interesting points of each scenario.

module tb_burst_checker;

  localparam int BL       = 16;
  localparam int LW       = 8;
  localparam int SW       = 2;
  localparam int LEN_SAT  = (1 << LW) - 1;
  localparam int STAT_SAT = (1 << SW) - 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          clear = 1'b0;
  logic          din   = 1'b0;
  logic          rdy   = 1'b0;
  logic          res_valid;
  logic          res_ok;
  logic [LW-1:0] res_len;
  logic [SW-1:0] ok_cnt;
  logic [SW-1:0] err_cnt;
  logic          ovf;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_run   = 0;
  bit m_valid = 1'b0;
  bit m_ok    = 1'b0;
  int m_len   = 0;
  int m_okc   = 0;
  int m_errc  = 0;
  bit m_ovf   = 1'b0;
  bit m_busy  = 1'b0;
  bit e_eob;
  bit e_ok;
  bit e_drop;
  int e_len;

  always #5 clk = ~clk;

  burst_checker #(
    .BURST_LEN (BL),
    .LEN_W     (LW),
    .STAT_W    (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (en),
    .i_clear     (clear),
    .i_din       (din),
    .o_res_valid (res_valid),
    .i_res_ready (rdy),
    .o_res_ok    (res_ok),
    .o_res_len   (res_len),
    .o_ok_cnt    (ok_cnt),
    .o_err_cnt   (err_cnt),
    .o_ovf       (ovf),
    .o_busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a burst is a run of high samples while enabled; the first low sample ends it.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_run = 0; m_valid = 1'b0; m_ok = 1'b0; m_len = 0;
      m_okc = 0; m_errc = 0; m_ovf = 1'b0; m_busy = 1'b0;
    end else begin
      e_eob = 1'b0; e_ok = 1'b0; e_len = 0;
      if (!en) begin
        m_run = 0;
      end else if (din) begin
        m_run = m_run + 1;
      end else if (m_run > 0) begin
        e_eob = 1'b1;
        e_ok  = (m_run == BL);
        e_len = (m_run > LEN_SAT) ? LEN_SAT : m_run;
        m_run = 0;
      end
      e_drop = e_eob && m_valid && !rdy;
      if (e_eob && !e_drop) begin
        m_valid = 1'b1; m_ok = e_ok; m_len = e_len;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      if (clear) begin
        m_okc = 0; m_errc = 0; m_ovf = 1'b0;
      end else begin
        if (e_drop) m_ovf = 1'b1;
        if (e_eob && e_ok && m_okc < STAT_SAT) m_okc = m_okc + 1;
        if (e_eob && !e_ok && m_errc < STAT_SAT) m_errc = m_errc + 1;
      end
      m_busy = (m_run > 0);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("res_valid", res_valid, m_valid);
      if (m_valid) begin
        chk("res_ok", res_ok, m_ok);
        chk("res_len", res_len, m_len);
      end
      chk("ok_cnt", ok_cnt, m_okc);
      chk("err_cnt", err_cnt, m_errc);
      chk("ovf", ovf, m_ovf);
      chk("busy", busy, m_busy);
    end
  end

  task automatic step(input bit e, input bit d, input bit r, input bit c);
    en = e; din = d; rdy = r; clear = c;
    @(posedge clk);
    #2;
  endtask

  // n high samples then the terminating low sample (optionally with clear).
  task automatic burst(input int n, input bit r, input bit c_end);
    repeat (n) step(1'b1, 1'b1, r, 1'b0);
    step(1'b1, 1'b0, r, c_end);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_ok"}, res_ok, 0);
    chk({tag, "_len"}, res_len, 0);
    chk({tag, "_okc"}, ok_cnt, 0);
    chk({tag, "_errc"}, err_cnt, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // exact-length burst, result one edge after the first low sample
    repeat (BL) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t1_pre_valid", res_valid, 0);
    chk("t1_busy", busy, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t1_valid", res_valid, 1);
    chk("t1_ok", res_ok, 1);
    chk("t1_len", res_len, 16);
    chk("t1_okc", ok_cnt, 1);
    chk("t1_errc", err_cnt, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t1_taken", res_valid, 0);

    // short then long bursts
    burst(5, 1'b1, 1'b0);
    chk("t2_short_ok", res_ok, 0);
    chk("t2_short_len", res_len, 5);
    chk("t2_short_errc", err_cnt, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (20) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t2_long_busy", busy, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t2_long_ok", res_ok, 0);
    chk("t2_long_len", res_len, 20);
    chk("t2_long_errc", err_cnt, 2);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // consumer stalled: second result dropped, first held
    burst(BL, 1'b0, 1'b0);
    chk("t3_first_len", res_len, 16);
    chk("t3_first_okc", ok_cnt, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    burst(7, 1'b0, 1'b0);
    chk("t3_held_valid", res_valid, 1);
    chk("t3_held_len", res_len, 16);
    chk("t3_held_ok", res_ok, 1);
    chk("t3_ovf", ovf, 1);
    chk("t3_errc", err_cnt, 3);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t3_drained", res_valid, 0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("clr_okc", ok_cnt, 0);
    chk("clr_errc", err_cnt, 0);
    chk("clr_ovf", ovf, 0);

    // new result lands on the same edge the old one transfers
    burst(BL, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (9) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_valid", res_valid, 1);
    chk("t4_len", res_len, 9);
    chk("t4_ok", res_ok, 0);
    chk("t4_ovf", ovf, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_taken", res_valid, 0);

    // enable dropped mid-burst, then re-raised with din already high
    repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_busy", busy, 0);
    chk("t5_valid", res_valid, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_okc", ok_cnt, 1);
    chk("t5_errc", err_cnt, 1);
    burst(3, 1'b1, 1'b0);
    chk("t5_rise_len", res_len, 3);
    chk("t5_rise_errc", err_cnt, 2);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // asynchronous reset mid-burst; the tail is a fresh short burst
    repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    burst(3, 1'b1, 1'b0);
    chk("rst_tail_len", res_len, 3);
    chk("rst_tail_errc", err_cnt, 1);
    chk("rst_tail_okc", ok_cnt, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // 2-bit ok counter saturates, then clear beats a same-cycle increment and drop
    repeat (4) begin
      burst(BL, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
    end
    chk("sat_okc4", ok_cnt, 3);
    burst(BL, 1'b0, 1'b0);
    chk("sat_okc5", ok_cnt, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    burst(BL, 1'b0, 1'b1);
    chk("clr_eob_okc", ok_cnt, 0);
    chk("clr_eob_ovf", ovf, 0);
    chk("clr_eob_valid", res_valid, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // measured length saturates at the field maximum
    burst(260, 1'b1, 1'b0);
    chk("lensat_len", res_len, 255);
    chk("lensat_ok", res_ok, 0);
    chk("lensat_errc", err_cnt, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
